// File: rtl/uart_tx_drain.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_drain
// Brief    : Pops bytes from the upstream transmit fifo and serialises them
//            onto the TX line as 1 start bit, DATA_WIDTH data bits (LSB
//            first), no parity and STOP_BITS stop bits.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_drain #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_data_in,
  input  logic                  fifo_empty_in,
  output logic                  fifo_read_en_out,
  output logic                  tx_out,
  output logic                  busy_out,
  output logic                  frame_done_out
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [BAUD_W-1:0]       baud_q, baud_d;
  logic [IDX_W-1:0]        bit_q, bit_d;
  logic                    stop_q, stop_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    tx_q, tx_d;
  logic                    frame_done_q, frame_done_d;

  logic                    baud_done;
  logic                    last_stop;
  logic [IDX_W-1:0]        bit_next;

  // Pop only from IDLE, and never while the block is held in reset.
  assign fifo_read_en_out = rst && (state_q == ST_IDLE) && !fifo_empty_in;
  assign busy_out         = (state_q != ST_IDLE);
  assign tx_out           = tx_q;
  assign frame_done_out   = frame_done_q;

  // Next-state, counter and line-level computation for the frame sequencer.
  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    stop_d       = stop_q;
    shift_d      = shift_q;
    tx_d         = tx_q;
    baud_done    = (baud_q == BAUD_LAST);
    last_stop    = (STOP_BITS == 1) || stop_q;
    bit_next     = bit_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        stop_d = 1'b0;
        if (!fifo_empty_in) begin
          state_d = ST_FETCH;
        end
      end

      // Fifo read data is registered, so it is valid here, one cycle after the pop.
      ST_FETCH: begin
        shift_d = fifo_data_in;
        tx_d    = 1'b0;
        baud_d  = '0;
        state_d = ST_START;
      end

      ST_START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == IDX_LAST) begin
            stop_d  = 1'b0;
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            bit_d = bit_next;
            tx_d  = shift_q[bit_next];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      ST_STOP: begin
        tx_d = 1'b1;
        if (baud_done) begin
          baud_d = '0;
          if (last_stop) begin
            stop_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        tx_d    = 1'b1;
        baud_d  = '0;
        bit_d   = '0;
        stop_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // Registered pulse: raise it for the cycle the sequencer will spend in
    // the final baud slot of the last stop bit.
    frame_done_d = (state_d == ST_STOP) && (baud_d == BAUD_LAST) &&
                   ((STOP_BITS == 1) || stop_d);
  end

  // Sequencer state and registered outputs; reset forces the line high at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      baud_q       <= '0;
      bit_q        <= '0;
      stop_q       <= 1'b0;
      shift_q      <= '0;
      tx_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      stop_q       <= stop_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
`default_nettype wire
